// File: rtl/riscv_pkg.sv
// Shared types and helpers for the memory responder.
// Bus width default, FSM states and the address range check.
package riscv_pkg;

   localparam int DEF_BUS_WIDTH = 32;
   localparam int DEF_DEPTH     = 256;

   typedef enum logic [1:0] {
      RUN,
      LOAD,
      FULL
   } state_t;

   function automatic logic addr_ok(
      input logic [63:0] a,
      input int unsigned depth
   );
      return a < 64'(depth);
   endfunction

endpackage

// File: rtl/riscv_mem_array.sv
// Word array: one write port, two registered read ports.
// Data port is write-first, instruction port is read-first.
module riscv_mem_array
   import riscv_pkg::*;
#(
   parameter int W     = DEF_BUS_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          d_en,
   input  logic [AW-1:0] daddr,
   input  logic          i_en,
   input  logic [AW-1:0] iaddr,
   output logic [W-1:0]  rdata,
   output logic [W-1:0]  idata
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_d, rdata_q;
   logic [W-1:0] idata_d, idata_q;

   always_comb begin
      rdata_d = '0;
      idata_d = '0;
      if (d_en) begin
         rdata_d = (we && waddr == daddr) ? wdata : mem_q[daddr];
      end
      if (i_en) begin
         idata_d = mem_q[iaddr];
      end
   end

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         idata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
         idata_q <= idata_d;
      end
   end

   assign rdata = rdata_q;
   assign idata = idata_q;

endmodule

// File: rtl/riscv_mem_resp.sv
// Memory responder for the core's fetch and data buses.
// Holds the load FSM, load pointer, write mux and range checks.
module riscv_mem_resp
   import riscv_pkg::*;
#(
   parameter int BUS_WIDTH = DEF_BUS_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AW        = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] iaddr,
   output logic [BUS_WIDTH-1:0] idata,
   input  logic                 wr,
   input  logic [BUS_WIDTH-1:0] addr,
   input  logic [BUS_WIDTH-1:0] wdata,
   output logic [BUS_WIDTH-1:0] rdata,
   input  logic                 ld_start,
   input  logic                 ld_valid,
   input  logic [BUS_WIDTH-1:0] ld_data,
   input  logic                 ld_end,
   output logic                 busy,
   output logic [AW:0]          ld_count,
   output logic                 addr_err
);

   localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

   state_t         state_d, state_q;
   logic [AW:0]    cnt_d, cnt_q;
   logic           addr_err_d, addr_err_q;
   logic           run, d_ok, i_ok;
   logic           ld_we, core_we, we;
   logic [AW-1:0]  waddr;
   logic [BUS_WIDTH-1:0] wd;

   always_comb begin
      run     = (state_q == RUN);
      d_ok    = addr_ok(64'(addr), DEPTH);
      i_ok    = addr_ok(64'(iaddr), DEPTH);
      ld_we   = (state_q == LOAD) && ld_valid && !ld_start;
      core_we = run && wr && d_ok;
      we      = ld_we || core_we;
      waddr   = ld_we ? cnt_q[AW-1:0] : addr[AW-1:0];
      wd      = ld_we ? ld_data : wdata;
      addr_err_d = run && (!d_ok || !i_ok);
   end

   // ld_start wins over everything; ld_end exits after a same-cycle beat.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (ld_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (ld_start) begin
               cnt_d = '0;
            end else begin
               if (ld_valid) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == LAST) state_d = FULL;
               end
               if (ld_end) state_d = RUN;
            end
         end
         FULL: begin
            if (ld_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end else if (ld_end) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_err_q <= addr_err_d;
      end
   end

   riscv_mem_array #(
      .W     (BUS_WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .waddr (waddr),
      .wdata (wd),
      .d_en  (run && d_ok),
      .daddr (addr[AW-1:0]),
      .i_en  (run && i_ok),
      .iaddr (iaddr[AW-1:0]),
      .rdata (rdata),
      .idata (idata)
   );

   assign busy     = !run;
   assign ld_count = cnt_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_riscv_mem_resp.sv
// Directed bench for riscv_mem_resp with an expectation queue
// checked one cycle after each stimulus step.
module tb_riscv_mem_resp;

   localparam int DEPTH = 256;

   typedef enum int {K_IDATA, K_RDATA, K_ERR, K_BUSY, K_CNT} kind_t;
   typedef struct {
      kind_t       k;
      string       tag;
      logic [31:0] e;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] iaddr = '0, idata;
   logic        wr = 1'b0;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic        ld_start = 1'b0, ld_valid = 1'b0, ld_end = 1'b0;
   logic [31:0] ld_data = '0;
   logic        busy;
   logic [8:0]  ld_count;
   logic        addr_err;

   int total = 0;
   int bad = 0;
   exp_t q[$];
   logic [31:0] model [DEPTH];

   riscv_mem_resp dut (
      .clk      (clk),
      .reset    (reset),
      .iaddr    (iaddr),
      .idata    (idata),
      .wr       (wr),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ld_start (ld_start),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_end   (ld_end),
      .busy     (busy),
      .ld_count (ld_count),
      .addr_err (addr_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f(input int i);
      return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
   endfunction

   function automatic logic [31:0] h(input int i);
      return 32'h7000_0000 + 32'(i) * 32'd3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_(input kind_t k, input string tag,
                          input logic [31:0] e);
      exp_t x;
      x.k = k;
      x.tag = tag;
      x.e = e;
      q.push_back(x);
   endtask

   function automatic logic [31:0] obs_of(input kind_t k);
      case (k)
         K_IDATA: return idata;
         K_RDATA: return rdata;
         K_ERR:   return 32'(addr_err);
         K_BUSY:  return 32'(busy);
         default: return 32'(ld_count);
      endcase
   endfunction

   task automatic step();
      exp_t x;
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
         x = q.pop_front();
         chk(x.tag, obs_of(x.k), x.e);
      end
   endtask

   task automatic idle();
      wr = 1'b0;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_end = 1'b0;
   endtask

   initial begin
      // Reset held across a few edges, released between edges.
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("rst_idata", idata, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cnt", 32'(ld_count), 0);
      chk("rst_err", 32'(addr_err), 0);

      // Full load with overrun beats; core write during LOAD ignored.
      idle();
      ld_start = 1'b1;
      expect_(K_BUSY, "full_busy0", 1);
      expect_(K_CNT, "full_cnt0", 0);
      step();
      ld_start = 1'b0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         ld_valid = 1'b1;
         ld_data = (i < DEPTH) ? f(i) : 32'hBAD0_0000 + 32'(i);
         if (i < DEPTH) model[i] = f(i);
         wr = (i == 10);
         addr = 32'd2;
         wdata = 32'h1234_5678;
         if (i == 10) expect_(K_RDATA, "load_rdata", 0);
         if (i == DEPTH - 1) begin
            expect_(K_CNT, "full_cnt", DEPTH);
            expect_(K_BUSY, "full_busy", 1);
         end
         step();
      end
      expect_(K_CNT, "full_hold", DEPTH);
      idle();
      ld_end = 1'b1;
      expect_(K_BUSY, "full_exit", 0);
      step();
      idle();
      iaddr = 0;
      addr = 0;
      expect_(K_IDATA, "full_mem0", model[0]);
      step();
      iaddr = 2;
      expect_(K_IDATA, "load_wr_ign", model[2]);
      step();

      // Short program load.
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1;
         case (i)
            0: ld_data = 32'h0000_0013;
            1: ld_data = 32'h0010_0093;
            2: ld_data = 32'h0020_8113;
            default: ld_data = 32'hDEAD_BEEF;
         endcase
         model[i] = ld_data;
         step();
      end
      idle();
      ld_end = 1'b1;
      step();
      ld_end = 1'b0;
      expect_(K_CNT, "prog_cnt", 4);
      expect_(K_BUSY, "prog_busy", 0);
      for (int i = 0; i < 4; i++) begin
         iaddr = 32'(i);
         expect_(K_IDATA, $sformatf("prog_i%0d", i), model[i]);
         step();
      end

      // Write-first data port, read-first instruction port.
      wr = 1'b1;
      addr = 5;
      wdata = 32'hCAFE_F00D;
      iaddr = 5;
      expect_(K_RDATA, "wf_rdata", 32'hCAFE_F00D);
      expect_(K_IDATA, "rf_old", model[5]);
      expect_(K_ERR, "wf_err", 0);
      model[5] = 32'hCAFE_F00D;
      step();
      wr = 1'b0;
      expect_(K_IDATA, "rf_new", model[5]);
      expect_(K_RDATA, "rd_new", model[5]);
      step();

      // Out-of-range accesses.
      wr = 1'b1;
      addr = DEPTH;
      wdata = 32'h1111_1111;
      iaddr = 0;
      expect_(K_ERR, "oor_err", 1);
      expect_(K_RDATA, "oor_rdata", 0);
      expect_(K_IDATA, "oor_iok", model[0]);
      step();
      wr = 1'b0;
      addr = 0;
      iaddr = 1;
      expect_(K_ERR, "inr_err", 0);
      expect_(K_RDATA, "oor_drop", model[0]);
      step();
      iaddr = 32'h8000_0000;
      expect_(K_ERR, "ioor_err", 1);
      expect_(K_IDATA, "ioor_idata", 0);
      expect_(K_RDATA, "ioor_rdata", model[0]);
      step();
      iaddr = 0;

      // Reset in the middle of a load.
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ld_valid = 1'b1;
         ld_data = h(i);
         model[i] = h(i);
         step();
      end
      idle();
      #2;
      reset = 1'b0;
      #1;
      chk("mid_busy", 32'(busy), 0);
      chk("mid_cnt", 32'(ld_count), 0);
      chk("mid_idata", idata, 0);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         iaddr = 32'(i);
         expect_(K_IDATA, $sformatf("mid_i%0d", i), model[i]);
         expect_(K_BUSY, "mid_run", 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_mem_resp.md
Name: riscv_mem_resp

Overview:
Memory responder on the far end of the core's instruction-fetch and data buses. It answers instruction fetches (iaddr → idata) and data reads and writes (addr/wr/data → data) from one word-addressed array, with 1-cycle registered read latency. A sequential load port with an auto-incrementing pointer fills the array before or between runs. While loading, the core-facing ports are stalled.

Parameters:
BUS_WIDTH, 32, width of all address and data buses
DEPTH, 256, number of BUS_WIDTH-bit words in the array
AW, 8, index bits used, equal to clog2(DEPTH)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
iaddr  in  BUS_WIDTH  instruction word address from core
idata  out  BUS_WIDTH  instruction word to core
wr  in  1  data write enable from core
addr  in  BUS_WIDTH  data word address from core
wdata  in  BUS_WIDTH  write data from core (core data_out)
rdata  out  BUS_WIDTH  read data to core (core data_in)
ld_start  in  1  pulse: enter LOAD, clear load pointer
ld_valid  in  1  ld_data is valid this cycle
ld_data  in  BUS_WIDTH  word to store at load pointer
ld_end  in  1  pulse: leave LOAD/FULL, return to RUN
busy  out  1  high in LOAD and FULL
ld_count  out  AW+1  words accepted since last ld_start
addr_err  out  1  registered: last core access was out of range

Behaviour:
- Reset (reset=0, async): state=RUN; idata=0, rdata=0, ld_count=0, addr_err=0, busy=0. Array contents are not reset.
- Addressing is word-based: address a is in range iff a < DEPTH, using index a[AW-1:0]. Upper bits must be zero; otherwise the access is out of range.
- RUN, instruction port: idata <= mem[iaddr] at each rising edge, 1-cycle latency. Out-of-range → idata <= 0, addr_err <= 1.
- RUN, data port, wr=1 and in range: mem[addr] <= wdata. Write-first: rdata <= wdata on the same edge.
- RUN, data port, wr=0: rdata <= mem[addr]. Out-of-range → rdata <= 0, write dropped, addr_err <= 1.
- addr_err <= 1 if either core access is out of range this cycle, else 0. Evaluated only in RUN; forced to 0 in LOAD/FULL.
- Simultaneous data write and instruction read of the same index: the instruction port is read-first and returns the old word; the new word is visible on the next cycle.
- FSM states RUN, LOAD, FULL:
  - RUN --ld_start--> LOAD, with ld_count <= 0.
  - LOAD, ld_valid=1: mem[ld_count] <= ld_data, ld_count <= ld_count+1.
  - LOAD --(write accepted and ld_count==DEPTH-1)--> FULL.
  - LOAD or FULL --ld_end--> RUN.
  - LOAD or FULL --ld_start--> LOAD, ld_count <= 0 (restart; earlier words are kept in the array).
  - FULL: ld_valid ignored, no write, ld_count holds at DEPTH, no wrap.
  - Same-cycle events: ld_start beats ld_end. ld_valid in the same cycle as ld_start is ignored. ld_valid in the same cycle as ld_end is written, then the FSM exits.
- LOAD/FULL: busy=1 (combinational from state); idata <= 0, rdata <= 0; core wr ignored.
- ld_count holds its value after returning to RUN and is readable by the core-side controller.
- Reset asserted mid-LOAD: returns to RUN immediately; words already written stay in the array; ld_count=0.

Decomposition:
- Shared package riscv_pkg: BUS_WIDTH default, the state enum (RUN/LOAD/FULL), and a function that checks whether an address is in range.
- One sub-module, riscv_mem_array: a DEPTH×BUS_WIDTH array with one write port and two registered read ports (data port write-first, instruction port read-first).
- The top level holds the FSM, the load pointer, the write-port mux (load port vs core) and the range checks.

Test Plan:
- Reset low mid-run, then release → idata=0, rdata=0, busy=0, ld_count=0 in the first cycle after release.
- ld_start, then 4× ld_valid with 0x00000013, 0x00100093, 0x00208113, 0xDEADBEEF, then ld_end → ld_count=4, busy falls. iaddr=0..3 returns the same words, each 1 cycle after its address.
- RUN: wr=1, addr=5, wdata=0xCAFEF00D → rdata=0xCAFEF00D next cycle. Same cycle iaddr=5 → idata=old mem[5]. The following cycle iaddr=5 → idata=0xCAFEF00D.
- RUN: addr=DEPTH (256), wr=1 → write dropped, addr_err=1, rdata=0. Then addr=0, wr=0 → addr_err=0 and mem[0] unchanged. Also iaddr=0x80000000 → addr_err=1.
- LOAD with DEPTH+3 ld_valid beats → FULL after beat 256, ld_count=256, mem[0] not overwritten. During LOAD, core wr=1 to addr=2 is ignored and rdata=0.
- Assert reset after 10 load beats → state RUN, ld_count=0, and iaddr=0..9 still returns the loaded words.
